// File: rtl/currctrl_reset_sequencer_if.sv
// rtl/currctrl_reset_sequencer_if.sv - request/fault inputs and reset-sequencing outputs of the sequencer
interface currctrl_reset_sequencer_if;
   logic       req_in;
   logic       fault_in;
   logic       fault_clr;
   logic       dp_rst_n;
   logic       drv_en;
   logic       busy;
   logic [1:0] state;
   logic       fault_latched;
   logic [7:0] seq_count;

   modport master (
      output req_in, fault_in, fault_clr,
      input  dp_rst_n, drv_en, busy, state, fault_latched, seq_count
   );

   modport slave (
      input  req_in, fault_in, fault_clr,
      output dp_rst_n, drv_en, busy, state, fault_latched, seq_count
   );
endinterface

// File: rtl/currctrl_reset_sequencer.sv
// rtl/currctrl_reset_sequencer.sv - drain/hold/settle sequencing of datapath reset and gate-driver enable
module currctrl_reset_sequencer #(
   parameter int DRAIN_CYCLES  = 16,
   parameter int HOLD_CYCLES   = 64,
   parameter int SETTLE_CYCLES = 32,
   parameter int CNT_W         = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   currctrl_reset_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       seq_q, seq_d;
   logic             fault_meta_q, fault_s_q;
   logic             fault_latched_q, fault_latched_d;
   logic             dp_rst_n_q, drv_en_q, busy_q;
   logic             trig;

   assign trig = bus.req_in | fault_s_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      seq_d   = seq_q;
      unique case (state_q)
         ST_RUN: begin
            if (trig) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HOLD: begin
            // A live request parks the counter at its last value until released.
            if ((cnt_q == HOLD_LAST) && !trig) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end else if (cnt_q != HOLD_LAST) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SETTLE: begin
            // Drivers are still off, so a retrigger goes straight back to HOLD.
            if (trig) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               seq_d   = seq_q + 8'd1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_HOLD;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      fault_latched_d = fault_latched_q;
      if (fault_s_q) begin
         fault_latched_d = 1'b1;
      end else if (bus.fault_clr) begin
         fault_latched_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= ST_HOLD;
         cnt_q           <= '0;
         seq_q           <= '0;
         fault_meta_q    <= 1'b0;
         fault_s_q       <= 1'b0;
         fault_latched_q <= 1'b0;
         dp_rst_n_q      <= 1'b0;
         drv_en_q        <= 1'b0;
         busy_q          <= 1'b1;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         seq_q           <= seq_d;
         fault_meta_q    <= bus.fault_in;
         fault_s_q       <= fault_meta_q;
         fault_latched_q <= fault_latched_d;
         // Both enables decode from the same next state, so they can never disagree.
         dp_rst_n_q      <= (state_d != ST_HOLD);
         drv_en_q        <= (state_d == ST_RUN);
         busy_q          <= (state_d != ST_RUN);
      end
   end

   assign bus.state         = state_q;
   assign bus.dp_rst_n      = dp_rst_n_q;
   assign bus.drv_en        = drv_en_q;
   assign bus.busy          = busy_q;
   assign bus.fault_latched = fault_latched_q;
   assign bus.seq_count     = seq_q;

endmodule

// File: tb/tb_currctrl_reset_sequencer.sv
// tb/tb_currctrl_reset_sequencer.sv - scoreboard bench: expected output events queued by stimulus, popped by monitor
module tb_currctrl_reset_sequencer;

   localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_HOLD = 2'd2, S_SETTLE = 2'd3;

   typedef struct packed {
      int         edge_n;
      logic [1:0] st;
      logic       dp;
      logic       drv;
      logic       busy;
      logic       fl;
      logic [7:0] seq;
   } ev_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   done = 1'b0;
   ev_t  sb[$];

   currctrl_reset_sequencer_if bus ();

   currctrl_reset_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_ev(input int e, input logic [1:0] st, input logic [7:0] seq, input logic fl);
      ev_t ev;
      ev.edge_n = e;
      ev.st     = st;
      ev.dp     = (st != S_HOLD);
      ev.drv    = (st == S_RUN);
      ev.busy   = (st != S_RUN);
      ev.fl     = fl;
      ev.seq    = seq;
      sb.push_back(ev);
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic req_pulse_at(input int n);
      to_cyc(n);
      bus.req_in = 1'b1;
      @(negedge clk);
      bus.req_in = 1'b0;
   endtask

   // Monitor: any change in the observable output set is one event to match.
   initial begin
      ev_t cur, prev, exp_ev;
      prev = 'x;
      forever begin
         @(negedge clk);
         cur.edge_n = cyc;
         cur.st     = bus.state;
         cur.dp     = bus.dp_rst_n;
         cur.drv    = bus.drv_en;
         cur.busy   = bus.busy;
         cur.fl     = bus.fault_latched;
         cur.seq    = bus.seq_count;
         if (bus.dp_rst_n === 1'b0 && bus.drv_en === 1'b1) begin
            miscompares++;
            $display("FAIL invariant edge %0d: dp_rst_n=0 with drv_en=1", cyc);
         end
         if (cur[$bits(ev_t)-33:0] !== prev[$bits(ev_t)-33:0]) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_event edge %0d: got st=%0d dp=%b drv=%b busy=%b fl=%b seq=%0d, required none",
                        cyc, cur.st, cur.dp, cur.drv, cur.busy, cur.fl, cur.seq);
            end else begin
               exp_ev = sb.pop_front();
               if (cur !== exp_ev) begin
                  miscompares++;
                  $display("FAIL event: got edge=%0d st=%0d dp=%b drv=%b busy=%b fl=%b seq=%0d, required edge=%0d st=%0d dp=%b drv=%b busy=%b fl=%b seq=%0d",
                           cur.edge_n, cur.st, cur.dp, cur.drv, cur.busy, cur.fl, cur.seq,
                           exp_ev.edge_n, exp_ev.st, exp_ev.dp, exp_ev.drv, exp_ev.busy, exp_ev.fl, exp_ev.seq);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      bus.req_in    = 1'b0;
      bus.fault_in  = 1'b0;
      bus.fault_clr = 1'b0;

      // Reset values, then power-up sequence from last reset edge 3.
      push_ev(1, S_HOLD, 8'd0, 1'b0);
      push_ev(67, S_SETTLE, 8'd0, 1'b0);
      push_ev(99, S_RUN, 8'd1, 1'b0);
      to_cyc(3);
      reset_n = 1'b1;

      // One-cycle software request sampled at edge 111.
      push_ev(111, S_DRAIN, 8'd1, 1'b0);
      push_ev(127, S_HOLD, 8'd1, 1'b0);
      push_ev(191, S_SETTLE, 8'd1, 1'b0);
      push_ev(223, S_RUN, 8'd2, 1'b0);
      req_pulse_at(110);

      // Request at 241, extra pulse during DRAIN at 246 is ignored.
      push_ev(241, S_DRAIN, 8'd2, 1'b0);
      push_ev(257, S_HOLD, 8'd2, 1'b0);
      push_ev(321, S_SETTLE, 8'd2, 1'b0);
      push_ev(353, S_RUN, 8'd3, 1'b0);
      req_pulse_at(240);
      req_pulse_at(245);

      // Request held edges 361..560; release seen at edge 561.
      push_ev(361, S_DRAIN, 8'd3, 1'b0);
      push_ev(377, S_HOLD, 8'd3, 1'b0);
      push_ev(561, S_SETTLE, 8'd3, 1'b0);
      push_ev(593, S_RUN, 8'd4, 1'b0);
      to_cyc(360);
      bus.req_in = 1'b1;
      to_cyc(560);
      bus.req_in = 1'b0;

      // Retrigger 10 cycles into SETTLE (SETTLE entered at 681, pulse at 691).
      push_ev(601, S_DRAIN, 8'd4, 1'b0);
      push_ev(617, S_HOLD, 8'd4, 1'b0);
      push_ev(681, S_SETTLE, 8'd4, 1'b0);
      push_ev(691, S_HOLD, 8'd4, 1'b0);
      push_ev(755, S_SETTLE, 8'd4, 1'b0);
      push_ev(787, S_RUN, 8'd5, 1'b0);
      req_pulse_at(600);
      req_pulse_at(690);

      // Fault pulse over edges 801..803: sequence and flag at 803, clr at 804 ignored, clr at 811 honoured.
      push_ev(803, S_DRAIN, 8'd5, 1'b1);
      push_ev(811, S_DRAIN, 8'd5, 1'b0);
      push_ev(819, S_HOLD, 8'd5, 1'b0);
      push_ev(883, S_SETTLE, 8'd5, 1'b0);
      push_ev(915, S_RUN, 8'd6, 1'b0);
      to_cyc(800);
      bus.fault_in = 1'b1;
      to_cyc(803);
      bus.fault_in  = 1'b0;
      bus.fault_clr = 1'b1;
      to_cyc(804);
      bus.fault_clr = 1'b0;
      to_cyc(810);
      bus.fault_clr = 1'b1;
      to_cyc(811);
      bus.fault_clr = 1'b0;

      // Reset at HOLD cnt=30 (edge 978), then full 64/32 rerun.
      push_ev(931, S_DRAIN, 8'd6, 1'b0);
      push_ev(947, S_HOLD, 8'd6, 1'b0);
      push_ev(978, S_HOLD, 8'd0, 1'b0);
      push_ev(1042, S_SETTLE, 8'd0, 1'b0);
      push_ev(1074, S_RUN, 8'd1, 1'b0);
      req_pulse_at(930);
      to_cyc(977);
      reset_n = 1'b0;
      to_cyc(978);
      reset_n = 1'b1;

      to_cyc(1100);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL missing_events: got %0d events still pending, required 0 (next edge %0d)",
                  sb.size(), sb[0].edge_n);
      end
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      if (!done) begin
         $display("FAIL timeout: got no completion by 20000, required completion");
         $fatal(1);
      end
   end

endmodule
